// File: rtl/r_alu_arbiter_pkg.sv
// rtl/r_alu_arbiter_pkg.sv - R-type func codes, arbiter FSM states and legality check
package r_alu_arbiter_pkg;

  // r_func = {funct7[5], funct7[0], funct3}
  typedef enum logic [4:0] {
    R_ADD  = 5'b00000,
    R_SUB  = 5'b10000,
    R_SLL  = 5'b00001,
    R_SLT  = 5'b00010,
    R_SLTU = 5'b00011,
    R_XOR  = 5'b00100,
    R_SRL  = 5'b00101,
    R_SRA  = 5'b10101,
    R_OR   = 5'b00110,
    R_AND  = 5'b00111
  } r_func_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_t;

  // Only the ten base RV32I R-type ops; anything with funct7[0] set (M-extension) is rejected
  function automatic logic is_legal_r_func(input logic [4:0] f);
    case (f)
      R_ADD, R_SUB, R_SLL, R_SLT, R_SLTU,
      R_XOR, R_SRL, R_SRA, R_OR, R_AND: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/r_alu_arbiter_if.sv
// rtl/r_alu_arbiter_if.sv - requester, shared-unit and response signals of the arbiter
interface r_alu_arbiter_if #(
  parameter int XLEN = 32,
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
);

  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ-1:0][4:0]      req_func;
  logic [NREQ-1:0][XLEN-1:0] req_rv1;
  logic [NREQ-1:0][XLEN-1:0] req_rv2;

  logic [4:0]                alu_func;
  logic [XLEN-1:0]           alu_rv1;
  logic [XLEN-1:0]           alu_rv2;
  logic [XLEN-1:0]           alu_rd;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [IDW-1:0]            rsp_id;
  logic [XLEN-1:0]           rsp_data;
  logic                      rsp_err;

  // Requesters, the shared execute unit and the response consumer
  modport master (
    output req_valid, req_func, req_rv1, req_rv2, alu_rd, rsp_ready,
    input  req_ready, alu_func, alu_rv1, alu_rv2, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  // The arbiter itself
  modport slave (
    input  req_valid, req_func, req_rv1, req_rv2, alu_rd, rsp_ready,
    output req_ready, alu_func, alu_rv1, alu_rv2, rsp_valid, rsp_id, rsp_data, rsp_err
  );

endinterface

// File: rtl/r_alu_arbiter_rr_arbiter.sv
// rtl/r_alu_arbiter_rr_arbiter.sv - combinational round-robin grant search
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_idx_o,
  output logic            any_gnt_o
);

  // One extra bit so ptr+k cannot overflow before the explicit wrap compare
  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  // First asserted request at or after ptr, upward with wrap modulo NREQ
  always_comb begin
    logic [IDW:0] cand;
    cand      = '0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_gnt_o = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_i} + (IDW+1)'(k);
      if (cand >= NREQ_W) begin
        cand = cand - NREQ_W;
      end
      if (!any_gnt_o && req_i[cand[IDW-1:0]]) begin
        gnt_o[cand[IDW-1:0]] = 1'b1;
        gnt_idx_o            = cand[IDW-1:0];
        any_gnt_o            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/r_alu_arbiter.sv
// rtl/r_alu_arbiter.sv - round-robin sharing of one R-type execute unit between requesters
module r_alu_arbiter
  import r_alu_arbiter_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input logic             clk,
  input logic             reset,
  r_alu_arbiter_if.slave  bus
);

  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  arb_state_t      state_q;
  logic [IDW-1:0]  rr_ptr_q;
  logic [IDW-1:0]  rr_ptr_d;
  logic [IDW-1:0]  id_q;
  logic [4:0]      func_q;
  logic [XLEN-1:0] rv1_q;
  logic [XLEN-1:0] rv2_q;
  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [XLEN-1:0] rsp_data_q;
  logic            rsp_err_q;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            any_gnt;
  logic            func_legal;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .req_i     (bus.req_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_gnt_o (any_gnt)
  );

  assign func_legal = is_legal_r_func(func_q);

  // Explicit compare keeps the wrap correct when NREQ is not a power of two
  assign rr_ptr_d = (id_q == LAST_ID) ? '0 : id_q + IDW'(1);

  // Offer the grant only while idle and out of reset, so at most one ready bit is ever set
  assign bus.req_ready = (state_q == IDLE && reset) ? gnt : '0;

  assign bus.alu_func  = func_q;
  assign bus.alu_rv1   = rv1_q;
  assign bus.alu_rv2   = rv2_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

  // Accept -> one execute cycle on the shared unit -> hold response until consumed
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      func_q      <= R_ADD;
      rv1_q       <= '0;
      rv2_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_gnt) begin
            func_q  <= bus.req_func[gnt_idx];
            rv1_q   <= bus.req_rv1[gnt_idx];
            rv2_q   <= bus.req_rv2[gnt_idx];
            id_q    <= gnt_idx;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_q  <= func_legal ? bus.alu_rd : '0;
          rsp_id_q    <= id_q;
          rsp_err_q   <= !func_legal;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rr_ptr_q    <= rr_ptr_d;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_r_alu_arbiter.sv
// tb/tb_r_alu_arbiter.sv - scoreboard bench for r_alu_arbiter with a reference model
module tb_r_alu_arbiter;
  import r_alu_arbiter_pkg::*;

  localparam int XLEN = 32;
  localparam int NREQ = 2;

  typedef struct packed {
    logic [4:0]  func;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        err;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic done = 1'b0;
  logic gap_en = 1'b0;

  int   cyc = 0;
  logic rst_smp = 1'b1;

  int   n_tests = 0;
  int   n_fail = 0;

  op_t  pend_q [NREQ][$];
  int   rd_idx [NREQ];
  int   seen_cnt [NREQ];
  int   acc_cnt [NREQ];

  exp_t sb [$];
  int   ptr = 0;
  bit   busy = 1'b0;
  bit   front_seen = 1'b0;

  logic [32:0] stub_r;

  r_alu_arbiter_if #(.XLEN(XLEN), .NREQ(NREQ)) bus ();

  r_alu_arbiter #(.XLEN(XLEN), .NREQ(NREQ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference R-type semantics: {illegal, result}
  function automatic logic [32:0] ref_exec(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      5'b00000: return {1'b0, a + b};
      5'b10000: return {1'b0, a - b};
      5'b00001: return {1'b0, a << b[4:0]};
      5'b00010: return {1'b0, 31'd0, ($signed(a) < $signed(b))};
      5'b00011: return {1'b0, 31'd0, (a < b)};
      5'b00100: return {1'b0, a ^ b};
      5'b00101: return {1'b0, a >> b[4:0]};
      5'b10101: return {1'b0, 32'($signed(a) >>> b[4:0])};
      5'b00110: return {1'b0, a | b};
      5'b00111: return {1'b0, a & b};
      default:  return {1'b1, 32'd0};
    endcase
  endfunction

  // Shared execute unit stand-in; returns non-zero junk for illegal codes
  always_comb begin
    stub_r = ref_exec(bus.alu_func, bus.alu_rv1, bus.alu_rv2);
    bus.alu_rd = stub_r[32] ? ((bus.alu_rv1 ^ 32'hA5A5_5A5A) | 32'h1) : stub_r[31:0];
  end

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rst_smp <= reset;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Arbitration model: predicts the grant and pushes the expected response on accept
  task automatic track();
    logic [NREQ-1:0] eg;
    logic [32:0]     r;
    int              gi;
    exp_t            e;
    if (!reset) begin
      sb.delete();
      busy       = 1'b0;
      ptr        = 0;
      front_seen = 1'b0;
      return;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_valid[i] && bus.req_ready[i]) acc_cnt[i]++;
    end
    eg = '0;
    gi = -1;
    if (!busy) begin
      for (int k = 0; k < NREQ; k++) begin
        if (gi < 0 && bus.req_valid[(ptr + k) % NREQ]) gi = (ptr + k) % NREQ;
      end
    end
    if (gi >= 0) eg[gi] = 1'b1;
    chk("req_ready", bus.req_ready, eg);
    if (gi >= 0) begin
      r      = ref_exec(bus.req_func[gi], bus.req_rv1[gi], bus.req_rv2[gi]);
      e.id   = gi;
      e.data = r[31:0];
      e.err  = r[32];
      e.acc  = cyc;
      sb.push_back(e);
      busy = 1'b1;
    end
  endtask

  // Response monitor: compares against the scoreboard head while rsp_valid is up
  task automatic monitor();
    if (!reset) return;
    if (bus.rsp_valid) begin
      if (sb.size() == 0) begin
        chk("rsp_spurious", bus.rsp_valid, 1'b0);
      end else begin
        if (!front_seen) begin
          chk("rsp_latency", cyc - sb[0].acc, 2);
          front_seen = 1'b1;
        end
        chk("rsp_id", bus.rsp_id, sb[0].id);
        chk("rsp_data", bus.rsp_data, sb[0].data);
        chk("rsp_err", bus.rsp_err, sb[0].err);
        if (bus.rsp_ready) begin
          ptr        = (sb[0].id + 1) % NREQ;
          busy       = 1'b0;
          front_seen = 1'b0;
          void'(sb.pop_front());
        end
      end
    end else if (sb.size() > 0 && (cyc - sb[0].acc) >= 2) begin
      chk("rsp_late", bus.rsp_valid, 1'b1);
    end
  endtask

  // All checking happens on the falling edge, away from the DUT's active edge
  always @(negedge clk) begin
    if (!reset && !rst_smp) begin
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_id", bus.rsp_id, 0);
      chk("rst_rsp_data", bus.rsp_data, 0);
      chk("rst_rsp_err", bus.rsp_err, 0);
      chk("rst_alu_func", bus.alu_func, 5'b00000);
      chk("rst_alu_rv1", bus.alu_rv1, 0);
      chk("rst_alu_rv2", bus.alu_rv2, 0);
    end
    track();
    monitor();
    if (cyc > 50000) begin
      chk("watchdog_cycles", cyc, 50000);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
    if (done) begin
      chk("sb_drain", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  // Requester drivers: hold valid and payload until accepted, then load the next op
  initial begin
    bus.req_valid = '0;
    bus.req_func  = '0;
    bus.req_rv1   = '0;
    bus.req_rv2   = '0;
    for (int i = 0; i < NREQ; i++) begin
      rd_idx[i]   = 0;
      seen_cnt[i] = 0;
    end
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < NREQ; i++) begin
        if (acc_cnt[i] != seen_cnt[i]) begin
          seen_cnt[i]      = acc_cnt[i];
          bus.req_valid[i] = 1'b0;
        end
        if (!bus.req_valid[i] && rd_idx[i] < pend_q[i].size() &&
            (!gap_en || $urandom_range(0, 3) != 0)) begin
          bus.req_valid[i] = 1'b1;
          bus.req_func[i]  = pend_q[i][rd_idx[i]].func;
          bus.req_rv1[i]   = pend_q[i][rd_idx[i]].a;
          bus.req_rv2[i]   = pend_q[i][rd_idx[i]].b;
          rd_idx[i]++;
        end
      end
    end
  end

  task automatic push(input int r, input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    op_t o;
    o.func = f;
    o.a    = a;
    o.b    = b;
    pend_q[r].push_back(o);
  endtask

  function automatic bit drained();
    for (int i = 0; i < NREQ; i++) begin
      if (rd_idx[i] < pend_q[i].size() || bus.req_valid[i]) return 1'b0;
    end
    return (sb.size() == 0) && !bus.rsp_valid;
  endfunction

  task automatic wait_drain(input int budget, input bit rnd_ready);
    for (int n = 0; n < budget; n++) begin
      @(posedge clk);
      #2;
      if (rnd_ready) bus.rsp_ready = ($urandom_range(0, 3) != 0);
      if (drained()) break;
    end
    bus.rsp_ready = 1'b1;
  endtask

  logic [4:0] legal_tab [10] = '{R_ADD, R_SUB, R_SLL, R_SLT, R_SLTU, R_XOR, R_SRL, R_SRA, R_OR, R_AND};

  // Directed scenarios first, then a randomized soak
  initial begin
    int c0;
    logic [4:0] f;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) acc_cnt[i] = 0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;

    push(0, R_ADD, 32'd415, 32'd60);
    wait_drain(100, 1'b0);

    push(1, 5'b01000, 32'd7, 32'd9);
    wait_drain(100, 1'b0);

    push(0, R_SUB, 32'd6553, 32'd653);
    push(0, R_SUB, 32'd6553, 32'd653);
    push(1, R_XOR, 32'd696, 32'd939);
    push(1, R_XOR, 32'd696, 32'd939);
    wait_drain(100, 1'b0);

    bus.rsp_ready = 1'b0;
    push(0, R_SRA, 32'h8000_0350, 32'd325);
    push(1, R_ADD, 32'd1, 32'd2);
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) break;
    end
    repeat (4) @(posedge clk);
    #2 bus.rsp_ready = 1'b1;
    wait_drain(100, 1'b0);

    push(0, R_SLL, 32'd288, 32'd349);
    wait_drain(100, 1'b0);

    c0 = acc_cnt[0];
    push(0, R_SLT, 32'd696, 32'd623);
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      if (acc_cnt[0] != c0) break;
    end
    #2 reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    push(0, R_ADD, 32'd5, 32'd6);
    push(1, R_ADD, 32'd7, 32'd8);
    #2 reset = 1'b1;
    wait_drain(100, 1'b0);

    gap_en = 1'b1;
    for (int n = 0; n < 120; n++) begin
      f = ($urandom_range(0, 7) == 0) ? 5'($urandom) : legal_tab[$urandom_range(0, 9)];
      push(int'($urandom_range(0, NREQ - 1)), f,
           ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 1000)),
           ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)));
    end
    wait_drain(5000, 1'b1);

    repeat (2) @(posedge clk);
    done = 1'b1;
  end

endmodule
